uart_rx_cfg: RTL and testbench

Second-generation UART receiver with runtime-programmable baud divisor, 16x oversampling with 3-sample majority vote, optional odd/even parity, and 1 or 2 stop bits. Delivers received words on a valid/ready stream interface with a parity sideband. Flags framing errors, overrun and line break. Sits between the board RX pin and the bootloader byte FIFO / command parser.

---
 rtl/uart_rx_cfg.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// UART receiver: programmable baud divisor, 16x oversampling with 3-sample
// majority vote, optional odd/even parity, 1 or 2 stop bits, valid/ready output.
module uart_rx_cfg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  stop2,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_perr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  break_det
);

    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = $clog2(DATA_WIDTH);
    localparam int unsigned MID = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRK_WAIT
    } state_t;

    state_t                state;
    logic                  rx_meta;
    logic                  rx_sync;
    logic [DIV_WIDTH-1:0]  tick_cnt;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [SCW-1:0]        samp_cnt;
    logic                  smp0;
    logic                  smp1;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BCW-1:0]        bit_cnt;
    logic                  par_bit;
    logic                  pen_q;
    logic                  podd_q;
    logic                  stop2_q;

    logic                  tick;
    logic                  maj_pt;
    logic                  maj;
    logic                  data_perr;
    logic                  is_break;
    logic                  deliver;

    assign tick      = (state != IDLE) && (tick_cnt == div_q);
    assign maj_pt    = tick && (samp_cnt == SCW'(MID + 1));
    assign maj       = (smp0 & smp1) | (smp0 & rx_sync) | (smp1 & rx_sync);
    assign data_perr = pen_q && ((^shreg ^ par_bit) != podd_q);
    assign is_break  = (shreg == '0) && !(pen_q && par_bit);
    assign deliver   = maj_pt && maj &&
                       (((state == STOP1) && !stop2_q) || (state == STOP2));

    // Two-flop synchronizer for the asynchronous rx pin, idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Oversample tick generator, per-bit sample counter and vote captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
            smp0     <= 1'b1;
            smp1     <= 1'b1;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            samp_cnt <= (samp_cnt == SCW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + SCW'(1);
            if (samp_cnt == SCW'(MID - 1)) smp0 <= rx_sync;
            if (samp_cnt == SCW'(MID))     smp1 <= rx_sync;
        end else begin
            tick_cnt <= tick_cnt + DIV_WIDTH'(1);
        end
    end

    // Frame sequencing, config latching, framing-error and break pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_q     <= '0;
            pen_q     <= 1'b0;
            podd_q    <= 1'b0;
            stop2_q   <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            frame_err <= 1'b0;
            break_det <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            break_det <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state   <= START;
                        div_q   <= baud_div;
                        pen_q   <= parity_en;
                        podd_q  <= parity_odd;
                        stop2_q <= stop2;
                        bit_cnt <= '0;
                        par_bit <= 1'b0;
                    end
                end
                START: begin
                    if (maj_pt) state <= maj ? IDLE : DATA;
                end
                DATA: begin
                    if (maj_pt) begin
                        shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BCW'(1);
                        if (bit_cnt == BCW'(DATA_WIDTH - 1)) state <= pen_q ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (maj_pt) begin
                        par_bit <= maj;
                        state   <= STOP1;
                    end
                end
                STOP1: begin
                    if (maj_pt) begin
                        if (!maj) begin
                            if (is_break) begin
                                break_det <= 1'b1;
                                state     <= BRK_WAIT;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end
                        end else begin
                            state <= stop2_q ? STOP2 : IDLE;
                        end
                    end
                end
                STOP2: begin
                    if (maj_pt) begin
                        if (!maj) frame_err <= 1'b1;
                        state <= IDLE;
                    end
                end
                BRK_WAIT: begin
                    if (rx_sync) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output word register with overrun detection and valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_perr  <= 1'b0;
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!m_valid || m_ready) begin
                    m_data  <= shreg;
                    m_perr  <= data_perr;
                    m_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx_cfg;

    localparam int DLV  = 0;
    localparam int FERR = 1;
    localparam int BRK  = 2;
    localparam int NONE = 3;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic [7:0]  m_data;
    logic        m_perr;
    logic        m_valid;
    logic        m_ready;
    logic        frame_err;
    logic        overrun;
    logic        break_det;

    int errors = 0;
    int checks = 0;
    int n_ferr = 0, n_ovr = 0, n_brk = 0, n_hs = 0;
    int b_ferr, b_ovr, b_brk, b_hs;
    logic [8:0] hs_q[$];

    int cur_div = 3;
    bit cur_pen = 0, cur_podd = 0, cur_two = 0;

    uart_rx_cfg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .m_data     (m_data),
        .m_perr     (m_perr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .break_det  (break_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count pulses and record handshakes at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
            if (break_det) n_brk++;
            if (m_valid && m_ready) begin
                n_hs++;
                hs_q.push_back({m_perr, m_data});
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_clks();
        return (cur_div + 1) * 16;
    endfunction

    task automatic set_cfg(input int div, input bit pen, input bit podd, input bit two);
        cur_div = div; cur_pen = pen; cur_podd = podd; cur_two = two;
        baud_div = 16'(div); parity_en = pen; parity_odd = podd; stop2 = two;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic snap();
        b_ferr = n_ferr; b_ovr = n_ovr; b_brk = n_brk; b_hs = n_hs;
    endtask

    // Full frame; config inputs are scrambled during data bits to show they are latched.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
        int bc;
        bc = bit_clks();
        drive_bit(1'b0, bc);
        baud_div = 16'($urandom_range(0, 7));
        parity_en = 1'($urandom); parity_odd = 1'($urandom); stop2 = 1'($urandom);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
        set_cfg(cur_div, cur_pen, cur_podd, cur_two);
        if (cur_pen) drive_bit(pbit, bc);
        drive_bit(s1, bc);
        if (cur_two) drive_bit(s2, bc);
        drive_bit(1'b1, 2 * bc);
    endtask

    // Reference model: outcome of a frame from its line contents and config.
    function automatic int kind_of(input logic [7:0] d, input bit pen, input logic pbit,
                                   input logic s1, input bit two, input logic s2);
        if (!s1) return (d == 8'h00 && !(pen && pbit)) ? BRK : FERR;
        if (two && !s2) return FERR;
        return DLV;
    endfunction

    function automatic logic perr_of(input logic [7:0] d, input bit pen, input bit podd,
                                     input logic pbit);
        int ones;
        ones = $countones(d) + int'(pbit);
        if (!pen) return 1'b0;
        return podd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic check_result(input string tag, input int kind, input logic [7:0] d,
                                input logic perr);
        logic [8:0] w;
        chk({tag, "/ferr"}, n_ferr - b_ferr, (kind == FERR) ? 1 : 0);
        chk({tag, "/brk"},  n_brk - b_brk,   (kind == BRK) ? 1 : 0);
        chk({tag, "/ovr"},  n_ovr - b_ovr,   0);
        chk({tag, "/hs"},   n_hs - b_hs,     (kind == DLV) ? 1 : 0);
        chk({tag, "/valid"}, int'(m_valid),  0);
        if (kind == DLV && hs_q.size() > 0) begin
            w = hs_q.pop_front();
            chk({tag, "/word"}, int'(w), int'({perr, d}));
        end
        hs_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic pbit, s1, s2;
        bit pen, podd, two;
        int div, kind;
        logic [8:0] w;

        rst_n = 1'b0; rx = 1'b1; m_ready = 1'b1;
        set_cfg(3, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("rst/m_valid", int'(m_valid), 0);
        chk("rst/m_data", int'(m_data), 0);
        chk("rst/m_perr", int'(m_perr), 0);
        chk("rst/frame_err", int'(frame_err), 0);
        chk("rst/overrun", int'(overrun), 0);
        chk("rst/break_det", int'(break_det), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;

        // 8N1 basic word
        snap(); send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        check_result("a5", DLV, 8'hA5, 1'b0);

        // Even parity, wrong then right parity bit
        set_cfg(3, 1, 0, 0);
        snap(); send_frame(8'h37, 1'b0, 1'b1, 1'b1);
        check_result("p37bad", DLV, 8'h37, 1'b1);
        snap(); send_frame(8'h37, 1'b1, 1'b1, 1'b1);
        check_result("p37ok", DLV, 8'h37, 1'b0);

        // Framing error then recovery
        set_cfg(3, 0, 0, 0);
        snap(); send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        check_result("ferr55", FERR, 8'h55, 1'b0);
        snap(); send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
        check_result("rec0f", DLV, 8'h0F, 1'b0);

        // Randomized frames against the model
        for (int i = 0; i < 24; i++) begin
            div = int'($urandom_range(0, 3));
            pen = 1'($urandom); podd = 1'($urandom); two = 1'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d = 8'h00;
            pbit = 1'($urandom);
            s1 = ($urandom_range(0, 5) != 0);
            s2 = ($urandom_range(0, 5) != 0);
            if (!s1) s2 = 1'b1;
            set_cfg(div, pen, podd, two);
            kind = kind_of(d, pen, pbit, s1, two, s2);
            snap(); send_frame(d, pbit, s1, s2);
            check_result($sformatf("rnd%0d", i), kind, d, perr_of(d, pen, podd, pbit));
        end

        // Overrun: consumer stalled across two words
        set_cfg(3, 0, 0, 0);
        m_ready = 1'b0;
        snap(); send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        chk("ovr/valid1", int'(m_valid), 1);
        chk("ovr/data1", int'(m_data), 8'h11);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        chk("ovr/pulse", n_ovr - b_ovr, 1);
        chk("ovr/hold", int'(m_data), 8'h11);
        m_ready = 1'b1;
        @(posedge clk);
        #2;
        m_ready = 1'b0;
        chk("ovr/hs", n_hs - b_hs, 1);
        chk("ovr/cleared", int'(m_valid), 0);
        w = hs_q.pop_front();
        chk("ovr/hsword", int'(w), 9'h011);

        // Handshake lands exactly on the deliver cycle of 0x33
        snap(); send_frame(8'h44, 1'b0, 1'b1, 1'b1);
        hs_q.delete();
        drive_bit(1'b0, 64);
        for (int i = 0; i < 8; i++) begin
            d = 8'h33;
            drive_bit(d[i], 64);
        end
        rx = 1'b1;
        repeat (42) @(posedge clk);
        #2;
        m_ready = 1'b1;
        @(posedge clk);
        #2;
        m_ready = 1'b0;
        repeat (128) @(posedge clk);
        #2;
        chk("same/ovr", n_ovr - b_ovr, 0);
        chk("same/valid", int'(m_valid), 1);
        chk("same/data", int'(m_data), 8'h33);
        chk("same/hs", n_hs - b_hs, 1);
        w = hs_q.pop_front();
        chk("same/hsword", int'(w), 9'h044);
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        hs_q.delete();

        // Line break for two frame times, then a 2-stop-bit word
        snap();
        drive_bit(1'b0, 20 * 64);
        chk("brk/pulse", n_brk - b_brk, 1);
        chk("brk/ferr", n_ferr - b_ferr, 0);
        chk("brk/hs", n_hs - b_hs, 0);
        drive_bit(1'b1, 64);
        set_cfg(3, 0, 0, 1);
        snap(); send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        check_result("s2_5a", DLV, 8'h5A, 1'b0);

        // Short start glitch of 4 ticks
        set_cfg(3, 0, 0, 0);
        snap();
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 128);
        check_result("glitch", NONE, 8'h00, 1'b0);

        // Reset in the middle of a data phase, with a word held
        m_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 1'b1);
        chk("mid/held", int'(m_valid), 1);
        drive_bit(1'b0, 64);
        drive_bit(1'b1, 64);
        drive_bit(1'b0, 64);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("mid/m_valid", int'(m_valid), 0);
        chk("mid/m_data", int'(m_data), 0);
        chk("mid/pulses", int'({frame_err, overrun, break_det}), 0);
        rst_n = 1'b1;
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        hs_q.delete();
        snap(); send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        check_result("c3", DLV, 8'hC3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
